// File: rtl/decode_queue_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : decode_queue_pkg
// Brief   : Shared widths, queue defaults and entry type for the decode queue.
// Revision: 1.0
//------------------------------------------------------------------------------
package decode_queue_pkg;

   localparam int INSNBITS_SIZE  = 32;
   localparam int DQ_DEPTH       = 8;
   localparam int DQ_FETCH_WIDTH = 2;
   localparam int DQ_PC_SIZE     = 64;

   typedef struct packed {
      logic [INSNBITS_SIZE-1:0] insnbits;
      logic [DQ_PC_SIZE-1:0]    pc;
   } dq_entry_t;

endpackage
`default_nettype wire

// File: rtl/decode_queue_mem.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : decode_queue_mem
// Brief   : DEPTH-entry storage with PORTS write ports and one async read port.
// Revision: 1.0
//------------------------------------------------------------------------------
module decode_queue_mem #(
   parameter int DEPTH  = 8,
   parameter int WIDTH  = 96,
   parameter int PORTS  = 2,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic [PORTS-1:0]          wr_en,
   input  logic [PORTS*ADDR_W-1:0]   wr_addr,
   input  logic [PORTS*WIDTH-1:0]    wr_data,
   input  logic [ADDR_W-1:0]         rd_addr,
   output logic [WIDTH-1:0]          rd_data
);

   // Data array is deliberately unreset; validity is tracked by the occupancy count.
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int p = 0; p < PORTS; p++) begin
         if (wr_en[p]) begin
            r_mem[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*WIDTH +: WIDTH];
         end
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : decode_queue
// Brief   : Multi-lane fetch -> single-issue decode ring buffer with flush.
// Revision: 1.0
//------------------------------------------------------------------------------
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int FETCH_WIDTH = DQ_FETCH_WIDTH,
   parameter int DEPTH       = DQ_DEPTH,
   parameter int PC_SIZE     = DQ_PC_SIZE
) (
   input  logic                               in_clk,
   input  logic                               in_rst,
   input  logic                               in_flush,
   input  logic [FETCH_WIDTH-1:0]             in_fetch_valid,
   input  logic [FETCH_WIDTH*INSNBITS_SIZE-1:0] in_fetch_insnbits,
   input  logic [FETCH_WIDTH*PC_SIZE-1:0]     in_fetch_pc,
   output logic                               out_fetch_ready,
   output logic                               out_dec_valid,
   output logic [INSNBITS_SIZE-1:0]           out_dec_insnbits,
   output logic [PC_SIZE-1:0]                 out_dec_pc,
   input  logic                               in_dec_ready,
   output logic [$clog2(DEPTH+1)-1:0]         out_count,
   output logic                               out_stalled
);

   localparam int c_ptr_w   = $clog2(DEPTH);
   localparam int c_cnt_w   = $clog2(DEPTH+1);
   localparam int c_entry_w = INSNBITS_SIZE + PC_SIZE;

   generate
      if ((DEPTH < 2) || ((DEPTH & (DEPTH-1)) != 0) ||
          (FETCH_WIDTH < 1) || (FETCH_WIDTH > DEPTH)) begin : g_param_check
         $error("decode_queue: DEPTH must be a power of two >= FETCH_WIDTH >= 1");
      end
   endgenerate

   logic [c_ptr_w-1:0]               r_head;
   logic [c_ptr_w-1:0]               r_tail;
   logic [c_cnt_w-1:0]               r_count;

   logic [c_cnt_w-1:0]               w_k;
   logic                             w_run;
   logic                             w_gap;
   logic                             w_enq;
   logic                             w_deq;
   logic [c_cnt_w-1:0]               w_enq_n;
   logic [c_cnt_w-1:0]               w_deq_n;
   logic [FETCH_WIDTH-1:0]           w_wr_en;
   logic [FETCH_WIDTH*c_ptr_w-1:0]   w_wr_addr;
   logic [FETCH_WIDTH*c_entry_w-1:0] w_wr_data;
   logic [c_entry_w-1:0]             w_rd_data;

   // k counts the contiguous valid lanes from lane 0; anything past a hole is dropped.
   always_comb begin
      w_k   = '0;
      w_run = 1'b1;
      w_gap = 1'b0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (in_fetch_valid[i]) begin
            if (w_run) begin
               w_k = w_k + c_cnt_w'(1);
            end else begin
               w_gap = 1'b1;
            end
         end else begin
            w_run = 1'b0;
         end
      end
   end

   assign out_fetch_ready = (r_count <= c_cnt_w'(DEPTH - FETCH_WIDTH));
   assign out_dec_valid   = (r_count != '0);
   assign out_count       = r_count;
   assign out_stalled     = (|in_fetch_valid) && !out_fetch_ready;

   assign w_enq   = out_fetch_ready && (w_k != '0) && !in_flush;
   assign w_deq   = out_dec_valid && in_dec_ready && !in_flush;
   assign w_enq_n = w_enq ? w_k : '0;
   assign w_deq_n = c_cnt_w'(w_deq);

   always_comb begin
      w_wr_en   = '0;
      w_wr_addr = '0;
      w_wr_data = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         w_wr_en[i]                          = w_enq && (c_cnt_w'(i) < w_k);
         w_wr_addr[i*c_ptr_w +: c_ptr_w]     = r_tail + c_ptr_w'(i);
         w_wr_data[i*c_entry_w +: c_entry_w] = {in_fetch_insnbits[i*INSNBITS_SIZE +: INSNBITS_SIZE],
                                                in_fetch_pc[i*PC_SIZE +: PC_SIZE]};
      end
   end

   decode_queue_mem #(
      .DEPTH  (DEPTH),
      .WIDTH  (c_entry_w),
      .PORTS  (FETCH_WIDTH),
      .ADDR_W (c_ptr_w)
   ) u_mem (
      .clk     (in_clk),
      .wr_en   (w_wr_en),
      .wr_addr (w_wr_addr),
      .wr_data (w_wr_data),
      .rd_addr (r_head),
      .rd_data (w_rd_data)
   );

   // Head data is masked when empty so stale array contents never leak out.
   assign out_dec_insnbits = out_dec_valid ? w_rd_data[c_entry_w-1 -: INSNBITS_SIZE] : '0;
   assign out_dec_pc       = out_dec_valid ? w_rd_data[PC_SIZE-1:0] : '0;

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (in_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) begin
            r_tail <= r_tail + w_k[c_ptr_w-1:0];
         end
         if (w_deq) begin
            r_head <= r_head + c_ptr_w'(1);
         end
         r_count <= r_count + w_enq_n - w_deq_n;
      end
   end

`ifndef SYNTHESIS
   a_count_bound: assert property (@(posedge in_clk) disable iff (in_rst)
      r_count <= c_cnt_w'(DEPTH));
   a_no_lane_gap: assert property (@(posedge in_clk) disable iff (in_rst)
      !w_gap);
   a_stall_hold: assert property (@(posedge in_clk) disable iff (in_rst)
      (out_stalled && !in_flush) |=> ($stable(in_fetch_valid) &&
                                      $stable(in_fetch_insnbits) &&
                                      $stable(in_fetch_pc)));
`endif

endmodule
`default_nettype wire
